// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters, with optional packet lock.
// Latency: accept at T, tx_start high at T+1; req_ready only in IDLE with tx_busy low; tx_data held from accept until the frame ends.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       locked,
  output logic                       active
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(LOCK_TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state_q, state_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic            locked_q, locked_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            win_vld;
  logic [GW-1:0]   win_id;
  logic [GW-1:0]   cand;

  // Scan from the farthest candidate back to the nearest so the nearest valid one wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = grant_q;
    cand    = '0;
    if (locked_q) begin
      win_vld = req_valid[grant_q];
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        cand = GW'((int'(grant_q) + k) % NUM_REQ);
        if (req_valid[cand]) begin
          win_vld = 1'b1;
          win_id  = cand;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    locked_d   = locked_q;
    cnt_d      = cnt_q;
    req_ready  = '0;
    case (state_q)
      IDLE: begin
        if (!tx_busy && win_vld) begin
          req_ready[win_id] = 1'b1;
          tx_data_d         = req_data[{win_id, 3'b000} +: 8];
          grant_d           = win_id;
          locked_d          = ~req_last[win_id];
          cnt_d             = '0;
          tx_start_d        = 1'b1;
          state_d           = LAUNCH;
        end else if (locked_q && !req_valid[grant_q] && (LOCK_TIMEOUT > 0)) begin
          // Release happens on the edge where the count would reach LOCK_TIMEOUT.
          if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
            locked_d = 1'b0;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (!rst) req_ready = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      grant_q    <= GW'(NUM_REQ - 1);
      locked_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      locked_q   <= locked_d;
      cnt_q      <= cnt_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_q;
  assign locked   = locked_q;
  assign active   = (state_q != IDLE);

endmodule
